// File: rtl/btn_event_scheduler.sv
// Eight-button front end: sample divider, per-button shift-register debounce,
// rising-edge event detection, pending latch with sticky overflow, and a
// round-robin valid/ready server that hands out one button id at a time.
//
// state | meaning
// IDLE  | no event offered; arbitrate over pending bits
// OFFER | evt_valid high, evt_id held until the consumer accepts it
module btn_event_scheduler #(
  parameter int SAMPLE_DIV = 4,
  parameter int DEB_LEN    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] btn,
  input  logic       evt_ready,
  input  logic       clr_overflow,
  output logic       evt_valid,
  output logic [2:0] evt_id,
  output logic [7:0] pending,
  output logic       overflow
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [DEB_LEN-1:0] shreg [8];
  logic [7:0]         lvl;
  logic [7:0]         lvl_d;
  logic [7:0]         press;
  logic [7:0]         clr;
  logic [7:0]         ovf_hit;
  logic [2:0]         ptr;
  logic [2:0]         sel;
  logic               sel_found;
  logic               load;

  assign tick    = (div_cnt == DIV_LAST);
  assign press   = lvl & ~lvl_d;
  assign load    = (state == IDLE) && sel_found;
  assign clr     = load ? (8'(1) << sel) : 8'h00;
  // A press on a bit being loaded this cycle re-arms it; only a press onto a
  // bit that stays pending is a merge.
  assign ovf_hit = press & pending & ~clr;

  // Sample divider: wraps at SAMPLE_DIV-1, tick on the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Debounce history: shift one sample per tick into each channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) shreg[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < 8; i++) shreg[i] <= {shreg[i][DEB_LEN-2:0], btn[i]};
    end
  end

  // Debounced level is high only when the whole history is ones; keep a delayed copy for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl   <= '0;
      lvl_d <= '0;
    end else begin
      for (int i = 0; i < 8; i++) lvl[i] <= &shreg[i];
      lvl_d <= lvl;
    end
  end

  // Round-robin pick: first pending bit after ptr, wrapping back to ptr itself.
  always_comb begin
    logic [2:0] idx;
    idx       = '0;
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr + 3'(k);
      if (!sel_found && pending[idx]) begin
        sel       = idx;
        sel_found = 1'b1;
      end
    end
  end

  // Pending latch and sticky overflow; a new merge beats a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | press;
      if (|ovf_hit) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  // Event server FSM with registered valid/id and the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      ptr       <= 3'd7;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            evt_valid <= 1'b1;
            evt_id    <= sel;
            ptr       <= sel;
            state     <= OFFER;
          end else begin
            evt_valid <= 1'b0;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/btn_event_scheduler.md
Name: btn_event_scheduler

Overview:
- Front-end controller for the board's eight pushbuttons.
- Samples and debounces each button, converts each debounced press into a single event, and latches it as pending.
- Serves pending events one at a time to game logic over a valid/ready handshake, using round-robin arbitration so no button starves.
- Replaces per-button debounce/one-pulse instances plus fixed-priority encoding in the input path.

Parameters:
- SAMPLE_DIV, 4: clock cycles between debounce samples (>=1); sample tick when divider count == SAMPLE_DIV-1.
- DEB_LEN, 8: consecutive 1 samples required for the debounced level to be high (>=2).

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- btn  input  8  raw button levels, asynchronous to nothing (already on clk domain via board sync)
- evt_ready  input  1  consumer accepts event when high with evt_valid
- clr_overflow  input  1  clears sticky overflow flag
- evt_valid  output  1  event offered
- evt_id  output  3  index of offered button
- pending  output  8  currently latched, not-yet-offered events
- overflow  output  1  sticky: a press merged into an already-pending event

Behaviour:
- Reset (rst_n=0, async): divider=0, all shift registers=0, debounced levels=0, pending=0, evt_valid=0, evt_id=0, overflow=0, FSM=IDLE, rr pointer=7 (first search starts at id 0).
- Divider: counts 0..SAMPLE_DIV-1 and wraps. tick=1 in the cycle where count==SAMPLE_DIV-1. SAMPLE_DIV=1 gives tick every cycle.
- Debounce, per channel i:
  - On tick, shift btn[i] into a DEB_LEN-bit shift register.
  - lvl[i] register <= AND of all shift bits, evaluated every clock.
  - lvl_d[i] <= lvl[i] every clock.
  - press[i] = lvl[i] & ~lvl_d[i]: exactly one cycle per debounced rising edge.
  - Release and re-press requires the level to drop (any 0 sample) and then DEB_LEN fresh 1 samples.
- Pending, per bit:
  - Set on press[i].
  - Cleared when the FSM loads id i.
  - Set and clear in the same cycle: set wins, no overflow.
  - press[i] while pending[i]=1 and no clear that cycle: pending stays 1, overflow<=1.
  - A press of the id currently being offered is a new pending event, not an overflow.
- Overflow: sticky. clr_overflow clears it; a simultaneous new overflow wins (stays 1).
- FSM states IDLE, OFFER:
  - IDLE: if pending!=0, select the first set bit searching ptr+1, ptr+2, … mod 8, ending at ptr. Next cycle: evt_id<=sel, evt_valid<=1, pending[sel]<=0, ptr<=sel, go OFFER. If pending==0, stay in IDLE with evt_valid=0.
  - OFFER: evt_valid=1; evt_id held stable until handshake, regardless of new presses. On evt_valid&evt_ready: evt_valid<=0, go IDLE.
  - Consequence: minimum one idle cycle between events; max throughput is 1 event per 2 cycles.
- Latency: lvl rises at edge E0 → press high during the following cycle → pending set at E1 → evt_valid high after E2, i.e. 2 clocks after lvl rises, when the FSM is idle.
- Arbitration is evaluated only in IDLE. Pending bits set during OFFER wait for the next IDLE.
- Reset mid-OFFER: event is lost, everything returns to reset values immediately, no spurious valid after release.
- Width rules: ptr and evt_id are 3 bits; pointer increment wraps 7→0. Divider width = clog2(SAMPLE_DIV), minimum 1 bit.

Test Plan (SAMPLE_DIV=1, DEB_LEN=8 unless noted):
- Glitch: btn[3]=1 for 7 cycles, then 0 → no evt_valid and pending stays 0. btn[3]=1 held 8+ cycles → exactly one event, evt_id=3, evt_valid rising 2 cycles after lvl[3]; holding longer produces no further events.
- Round-robin: btn[0], btn[2], btn[5] rise together, evt_ready=1 → events 0, 2, 5 with evt_valid low one cycle between each. Then press 5 and 0 together (ptr=5) → order 0, then 5.
- Backpressure: evt_ready=0, press btn[1] → evt_valid=1, evt_id=1 held. Press btn[4] → pending=8'h10 and evt_id stays 1. Raise evt_ready → next event id=4.
- Overflow: evt_ready=0, btn[2] pressed and offered. Press btn[6] twice (release ≥1 sample between) → overflow=1 and only one id-6 event is delivered. clr_overflow pulse → overflow=0; clr_overflow coinciding with a new merge → overflow stays 1.
- Reset: assert rst_n=0 mid-OFFER with pending=8'h0A → all outputs 0 within the same cycle. After release, no event until a new full debounce.
- SAMPLE_DIV=4: btn[7] high for 31 cycles aligned to ticks → no event; high 32 cycles → one event id=7.
